// File: rtl/pulse_seq_scheduler.sv
// Pulse sequence scheduler: queues timed pulse commands in a circular FIFO and
// plays them out to a pulse generator, one pulse at a time.
//
// Ports:
//   ACLK, ARESETN      clock and asynchronous active-low reset
//   cmd_valid/ready    command push handshake
//   cmd_delay          idle cycles before the pulse fires
//   cmd_param          parameter word for the pulse generator
//   cmd_last           final command of a sequence
//   start, abort       single-cycle sequence control strobes
//   pg_trigger         single-cycle fire strobe to the pulse generator
//   pg_param           parameter of the current pulse
//   pg_done            pulse generator completion strobe
//   busy               sequence in progress
//   seq_done           last entry of a sequence completed
//   underrun           FIFO ran dry before a last entry completed
//   level              FIFO occupancy
module pulse_seq_scheduler #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DLY_W = 16,
  parameter int unsigned PRM_W = 32
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [DLY_W-1:0]       cmd_delay,
  input  logic [PRM_W-1:0]       cmd_param,
  input  logic                   cmd_last,
  input  logic                   start,
  input  logic                   abort,
  output logic                   pg_trigger,
  output logic [PRM_W-1:0]       pg_param,
  input  logic                   pg_done,
  output logic                   busy,
  output logic                   seq_done,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = 1 + DLY_W + PRM_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_FIRE,
    ST_PG_BUSY
  } state_t;

  // Reset synchroniser: asserts asynchronously, releases on the second edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  state_t           state;
  logic [DLY_W-1:0] dly_cnt;
  logic             last_q;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_nxt;
  logic [EW-1:0]    head;
  logic             full;
  logic             pop;
  logic             push;

  assign full = (level == LW'(DEPTH));
  assign head = mem[rd_ptr];
  assign pop  = (state == ST_LOAD) && !abort;
  // A push at full is still taken when the head leaves on the same edge,
  // since the slot being read frees up; otherwise a full FIFO drops it.
  assign push = cmd_valid && !abort && (!full || pop);

  // Occupancy after this edge's push/pop.
  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + LW'(1);
    end else if (pop && !push) begin
      level_nxt = level - LW'(1);
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_last, cmd_delay, cmd_param};
    end
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      cmd_ready <= 1'b1;
    end else if (abort) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      cmd_ready <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level     <= level_nxt;
      cmd_ready <= (level_nxt != LW'(DEPTH));
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      dly_cnt    <= '0;
      last_q     <= 1'b0;
      pg_trigger <= 1'b0;
      pg_param   <= '0;
      busy       <= 1'b0;
      seq_done   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      pg_trigger <= 1'b0;
      seq_done   <= 1'b0;
      underrun   <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && (level != LW'(0))) begin
              state <= ST_LOAD;
              busy  <= 1'b1;
            end
          end
          ST_LOAD: begin
            pg_param <= head[PRM_W-1:0];
            dly_cnt  <= head[PRM_W +: DLY_W];
            last_q   <= head[EW-1];
            state    <= ST_WAIT;
          end
          ST_WAIT: begin
            if (dly_cnt == DLY_W'(0)) begin
              state      <= ST_FIRE;
              pg_trigger <= 1'b1;
            end else begin
              dly_cnt <= dly_cnt - DLY_W'(1);
            end
          end
          ST_FIRE: begin
            state <= ST_PG_BUSY;
          end
          ST_PG_BUSY: begin
            if (pg_done) begin
              if (last_q) begin
                seq_done <= 1'b1;
                state    <= ST_IDLE;
                busy     <= 1'b0;
              end else if (level != LW'(0)) begin
                state <= ST_LOAD;
              end else begin
                underrun <= 1'b1;
                state    <= ST_IDLE;
                busy     <= 1'b0;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_seq_scheduler.sv
// Self-checking bench for pulse_seq_scheduler: an event-time model of the
// command queue and pulse schedule is compared against the DUT every cycle,
// plus hand-computed timing and parameter expectations per scenario.
module tb_pulse_seq_scheduler;

  localparam int unsigned DEPTH = 8;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_delay;
  logic [31:0] cmd_param;
  logic        cmd_last;
  logic        start;
  logic        abort;
  logic        pg_trigger;
  logic [31:0] pg_param;
  logic        pg_done;
  logic        busy;
  logic        seq_done;
  logic        underrun;
  logic [3:0]  level;

  logic        pg_done_auto;
  logic        pg_done_man;
  bit          auto_en;

  assign pg_done = pg_done_auto | pg_done_man;

  always #5 ACLK = ~ACLK;

  pulse_seq_scheduler #(.DEPTH(DEPTH), .DLY_W(16), .PRM_W(32)) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_delay  (cmd_delay),
    .cmd_param  (cmd_param),
    .cmd_last   (cmd_last),
    .start      (start),
    .abort      (abort),
    .pg_trigger (pg_trigger),
    .pg_param   (pg_param),
    .pg_done    (pg_done),
    .busy       (busy),
    .seq_done   (seq_done),
    .underrun   (underrun),
    .level      (level)
  );

  int vectors     = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [15:0] d;
    logic [31:0] p;
    logic        l;
  } cmd_t;

  cmd_t        q[$];
  int          cyc        = 0;
  int          hold       = 2;
  bit          running    = 0;
  bit          cur_last   = 0;
  logic [31:0] cur_param  = '0;
  int          load_at    = -1;
  int          fire_at    = -1;
  int          await_from = -1;
  bit          exp_trig   = 0;
  bit          exp_sdone  = 0;
  bit          exp_under  = 0;
  int          m_n;
  bit          m_pop;
  cmd_t        m_c;

  // Edge-indexed schedule: each pulse is a pop edge, a fire edge D+1 later,
  // then a pg_done wait starting the edge after firing.
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      q.delete();
      running = 0; cur_last = 0; cur_param = '0;
      load_at = -1; fire_at = -1; await_from = -1;
      exp_trig = 0; exp_sdone = 0; exp_under = 0;
      hold = 2;
    end else begin
      exp_trig = 0; exp_sdone = 0; exp_under = 0;
      if (hold > 0) begin
        hold--;
      end else if (abort) begin
        q.delete();
        running = 0; load_at = -1; fire_at = -1; await_from = -1;
      end else begin
        m_n   = q.size();
        m_pop = 0;
        if (!running && start && m_n > 0) begin
          running = 1;
          load_at = cyc + 1;
        end
        if (load_at == cyc) begin
          m_c       = q.pop_front();
          cur_param = m_c.p;
          cur_last  = m_c.l;
          fire_at   = cyc + int'(m_c.d) + 1;
          load_at   = -1;
          m_pop     = 1;
        end
        if (fire_at == cyc) begin
          exp_trig   = 1;
          fire_at    = -1;
          await_from = cyc + 1;
        end else if (await_from >= 0 && cyc >= await_from && pg_done) begin
          await_from = -1;
          if (cur_last) begin
            exp_sdone = 1;
            running   = 0;
          end else if (m_n > 0) begin
            load_at = cyc + 1;
          end else begin
            exp_under = 1;
            running   = 0;
          end
        end
        if (cmd_valid && (m_n < DEPTH || m_pop)) begin
          m_c = '{d: cmd_delay, p: cmd_param, l: cmd_last};
          q.push_back(m_c);
        end
      end
      cyc++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge ACLK) begin
    chk("pg_trigger", 64'(pg_trigger), 64'(exp_trig));
    chk("seq_done",   64'(seq_done),   64'(exp_sdone));
    chk("underrun",   64'(underrun),   64'(exp_under));
    chk("busy",       64'(busy),       64'(running));
    chk("level",      64'(level),      64'(q.size()));
    chk("cmd_ready",  64'(cmd_ready),  64'(q.size() != DEPTH));
    chk("pg_param",   64'(pg_param),   64'(cur_param));
  end

  // Event log for hand-computed expectations.
  int          trig_edges[$];
  logic [31:0] trig_params[$];
  int          sd_cnt  = 0;
  int          sd_edge = -1;
  int          un_cnt  = 0;

  always @(negedge ACLK) begin
    if (pg_trigger === 1'b1) begin
      trig_edges.push_back(cyc - 1);
      trig_params.push_back(pg_param);
    end
    if (seq_done === 1'b1) begin
      sd_cnt++;
      sd_edge = cyc - 1;
    end
    if (underrun === 1'b1) un_cnt++;
  end

  // Pulse generator stand-in: done two cycles after each trigger.
  int resp_cnt = 0;
  initial begin
    pg_done_auto = 1'b0;
    forever begin
      @(negedge ACLK);
      pg_done_auto = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) pg_done_auto = 1'b1;
      end
      if (auto_en && pg_trigger === 1'b1) resp_cnt = 2;
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input int d, input int p, input bit l);
    cmd_valid = 1'b1;
    cmd_delay = 16'(d);
    cmd_param = 32'(p);
    cmd_last  = l;
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int k;
    k = 0;
    while (busy && k < max) begin
      @(negedge ACLK);
      k++;
    end
    chk(name, 64'(busy), 64'd0);
  endtask

  int s, t0, sd0, un0, k;

  initial begin
    ARESETN = 1'b0; cmd_valid = 1'b0; cmd_delay = '0; cmd_param = '0; cmd_last = 1'b0;
    start = 1'b0; abort = 1'b0; pg_done_man = 1'b0; auto_en = 1;
    repeat (2) @(negedge ACLK);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_param", 64'(pg_param), 64'd0);
    ARESETN = 1'b1;
    repeat (3) @(negedge ACLK);

    // Basic three-pulse sequence.
    t0 = trig_edges.size(); sd0 = sd_cnt; un0 = un_cnt;
    push(0, 1, 0); push(4, 2, 0); push(0, 3, 1);
    s = cyc;
    start_pulse();
    wait_idle(100, "t1_idle");
    repeat (2) @(negedge ACLK);
    chk("t1_ntrig", 64'(trig_edges.size() - t0), 64'd3);
    if (trig_edges.size() >= t0 + 3) begin
      chk("t1_trig1_lat", 64'(trig_edges[t0] - s), 64'd2);
      chk("t1_trig2_lat", 64'(trig_edges[t0+1] - s), 64'd11);
      chk("t1_trig3_lat", 64'(trig_edges[t0+2] - s), 64'd16);
      chk("t1_param1", 64'(trig_params[t0]), 64'd1);
      chk("t1_param2", 64'(trig_params[t0+1]), 64'd2);
      chk("t1_param3", 64'(trig_params[t0+2]), 64'd3);
    end
    chk("t1_seq_done_cnt", 64'(sd_cnt - sd0), 64'd1);
    chk("t1_seq_done_lat", 64'(sd_edge - s), 64'd19);
    chk("t1_underrun", 64'(un_cnt - un0), 64'd0);

    // Full FIFO, ignored overflow push, push+pop at full.
    t0 = trig_edges.size(); sd0 = sd_cnt;
    for (int i = 0; i < 8; i++) push(3, 'h10 + i, 0);
    chk("t2_full_level", 64'(level), 64'd8);
    chk("t2_full_ready", 64'(cmd_ready), 64'd0);
    push(3, 'h77, 1);
    chk("t2_overflow_level", 64'(level), 64'd8);
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    cmd_valid = 1'b1; cmd_delay = 16'd1; cmd_param = 32'h99; cmd_last = 1'b1;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    chk("t2_pushpop_level", 64'(level), 64'd8);
    wait_idle(400, "t2_idle");
    repeat (2) @(negedge ACLK);
    chk("t2_ntrig", 64'(trig_edges.size() - t0), 64'd9);
    if (trig_edges.size() >= t0 + 9) begin
      chk("t2_first_param", 64'(trig_params[t0]), 64'h10);
      chk("t2_last_param", 64'(trig_params[t0+8]), 64'h99);
    end
    chk("t2_seq_done", 64'(sd_cnt - sd0), 64'd1);
    chk("t2_end_level", 64'(level), 64'd0);

    // Underrun: single non-last command.
    t0 = trig_edges.size(); sd0 = sd_cnt; un0 = un_cnt;
    push(2, 'hAA, 0);
    start_pulse();
    wait_idle(100, "t3_idle");
    repeat (2) @(negedge ACLK);
    chk("t3_ntrig", 64'(trig_edges.size() - t0), 64'd1);
    chk("t3_underrun", 64'(un_cnt - un0), 64'd1);
    chk("t3_no_seq_done", 64'(sd_cnt - sd0), 64'd0);

    // Abort during a long WAIT, with simultaneous push and start.
    t0 = trig_edges.size();
    for (int i = 0; i < 4; i++) push(1000, 'h40 + i, i == 3);
    start_pulse();
    repeat (4) @(negedge ACLK);
    abort = 1'b1; start = 1'b1;
    cmd_valid = 1'b1; cmd_delay = 16'd0; cmd_param = 32'h55; cmd_last = 1'b1;
    @(negedge ACLK);
    abort = 1'b0; start = 1'b0; cmd_valid = 1'b0;
    chk("t4_abort_busy", 64'(busy), 64'd0);
    chk("t4_abort_level", 64'(level), 64'd0);
    chk("t4_abort_ready", 64'(cmd_ready), 64'd1);
    start_pulse();
    repeat (3) @(negedge ACLK);
    chk("t4_restart_busy", 64'(busy), 64'd0);
    chk("t4_no_trig", 64'(trig_edges.size() - t0), 64'd0);

    // Empty-FIFO start and stray pg_done while idle.
    t0 = trig_edges.size(); sd0 = sd_cnt; un0 = un_cnt;
    start_pulse();
    pg_done_man = 1'b1;
    @(negedge ACLK);
    pg_done_man = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_events", 64'((trig_edges.size() - t0) + (sd_cnt - sd0) + (un_cnt - un0)), 64'd0);

    // Reset asserted in PG_BUSY with five entries queued.
    auto_en = 0;
    t0 = trig_edges.size();
    for (int i = 0; i < 6; i++) push(0, 'h60 + i, 0);
    start_pulse();
    k = 0;
    while (pg_trigger !== 1'b1 && k < 20) begin
      @(negedge ACLK);
      k++;
    end
    chk("t6_trig_seen", 64'(pg_trigger), 64'd1);
    @(negedge ACLK);
    chk("t6_pre_level", 64'(level), 64'd5);
    chk("t6_pre_busy", 64'(busy), 64'd1);
    #2 ARESETN = 1'b0;
    #1;
    chk("t6_rst_trig", 64'(pg_trigger), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_level", 64'(level), 64'd0);
    chk("t6_rst_ready", 64'(cmd_ready), 64'd1);
    chk("t6_rst_param", 64'(pg_param), 64'd0);
    chk("t6_rst_flags", 64'({seq_done, underrun}), 64'd0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (4) @(negedge ACLK);
    start_pulse();
    repeat (3) @(negedge ACLK);
    chk("t6_post_busy", 64'(busy), 64'd0);
    chk("t6_post_level", 64'(level), 64'd0);
    chk("t6_ntrig", 64'(trig_edges.size() - t0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
